// File: rtl/data_mem_resp_pkg.sv
// Shared types for the MEM-stage data-memory responder: FSM states, lane geometry,
// the captured request and a lane-insert helper.
package data_mem_resp_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] word_t;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] sel;
    word_t                wdata;
  } req_t;

  function automatic word_t lane_put(input word_t w, input logic [1:0] idx,
                                     input logic [LANE_W-1:0] b);
    word_t r;
    r      = w;
    r[idx] = b;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_resp_lane_next_sel.sv
// Picks the lowest selected lane strictly above idx; idx = -1 yields the first selected lane.
module lane_next_sel
  import data_mem_resp_pkg::*;
(
  input  logic [NUM_LANES-1:0] sel,
  input  logic signed [2:0]    idx,
  output logic [1:0]           nxt,
  output logic                 vld
);

  logic [NUM_LANES-1:0] hit;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_hit
    assign hit[k] = sel[k] && (idx < $signed(3'(k)));
  end

  always_comb begin
    nxt = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (hit[k]) nxt = 2'(k);
    end
  end

  assign vld = |hit;

endmodule

// File: rtl/data_mem_resp.sv
// Serialises MEM-stage word reads and byte-masked writes onto a req/ack byte bus,
// reassembling read bytes into a word presented with a one-cycle done pulse.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int EXT_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              ext_req,
  output logic              ext_we,
  output logic [EXT_AW-1:0] ext_addr,
  output logic [7:0]        ext_wdata,
  input  logic [7:0]        ext_rdata,
  input  logic              ext_ack
);

  state_t               state, state_nxt;
  req_t                 cap;
  logic [EXT_AW-1:0]    base;
  logic [1:0]           idx;
  word_t                rbuf, rword;
  logic [NUM_LANES-1:0] req_sel;
  logic [1:0]           first_idx, nxt_idx;
  logic                 first_vld, nxt_vld;
  logic                 accept, ack;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[31:EXT_AW];

  // Reads always fetch every lane; a write with no lanes selected never leaves IDLE.
  assign req_sel = mem_we ? mem_sel : '1;
  assign accept  = (state == ST_IDLE) && mem_ce && first_vld;
  assign ack     = (state == ST_XFER) && ext_ack;
  assign rword   = lane_put(rbuf, idx, ext_rdata);

  lane_next_sel u_first (
    .sel (req_sel),
    .idx (-3'sd1),
    .nxt (first_idx),
    .vld (first_vld)
  );

  lane_next_sel u_next (
    .sel (cap.sel),
    .idx ($signed({1'b0, idx})),
    .nxt (nxt_idx),
    .vld (nxt_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_XFER;
      ST_XFER: if (ack && !nxt_vld) state_nxt = cap.we ? ST_IDLE : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap       <= '0;
      base      <= '0;
      idx       <= '0;
      rbuf      <= '0;
      mem_rdata <= '0;
    end else if (accept) begin
      cap.we    <= mem_we;
      cap.sel   <= req_sel;
      cap.wdata <= mem_wdata;
      base      <= mem_we ? mem_addr[EXT_AW-1:0] : {mem_addr[EXT_AW-1:2], 2'b00};
      idx       <= first_idx;
    end else if (ack) begin
      if (!cap.we)            rbuf      <= rword;
      if (nxt_vld)            idx       <= nxt_idx;
      // Output word only changes when the final read byte lands.
      if (!cap.we && !nxt_vld) mem_rdata <= rword;
    end
  end

  always_comb begin
    mem_busy  = 1'b0;
    mem_done  = 1'b0;
    ext_req   = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
    case (state)
      ST_XFER: begin
        mem_busy  = 1'b1;
        ext_req   = 1'b1;
        ext_we    = cap.we;
        ext_addr  = base + EXT_AW'(idx);
        ext_wdata = cap.wdata[idx];
      end
      ST_DONE: mem_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Drives random and directed requests into data_mem_resp against a byte-wide device model
// and checks transfers, timing and read data against a transaction-level expectation.
module tb_data_mem_resp;

  localparam int AW = 17;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_ce, mem_we;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_sel;
  logic          mem_busy, mem_done;
  logic [31:0]   mem_rdata;
  logic          ext_req, ext_we, ext_ack;
  logic [AW-1:0] ext_addr;
  logic [7:0]    ext_wdata, ext_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:(1<<AW)-1];
  xfer_t       log_q[$];
  int          ack_delay = 0;
  int          cnt = 0;
  logic        stray_en = 1'b0;
  logic [31:0] last_rd = 32'h0;

  data_mem_resp #(.EXT_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  assign ext_rdata = mem[ext_addr];

  // Device: completes a transfer on a req&&ack edge, stores write bytes.
  always @(posedge clk) begin
    if (rst && ext_req && ext_ack) begin
      xfer_t e;
      e.we = ext_we;
      e.a  = ext_addr;
      e.d  = ext_we ? ext_wdata : ext_rdata;
      log_q.push_back(e);
      if (ext_we) mem[ext_addr] = ext_wdata;
      cnt = 0;
    end else if (ext_req) cnt++;
    else cnt = 0;
  end

  always @(negedge clk) begin
    if (ext_req) ext_ack = (cnt >= ack_delay);
    else         ext_ack = stray_en & 1'($urandom);
  end

  // One request; expectations are built from the transfer rules, not from the design's states.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input int dly, input string nm);
    xfer_t         exp_q[$];
    xfer_t         e;
    logic [AW-1:0] b;
    logic [31:0]   exp_rd;
    int n, len, busy_n, req_n, done_n, done_at;
    logic          hold;
    logic [AW+8:0] prev;
    b      = we ? addr[AW-1:0] : {addr[AW-1:2], 2'b00};
    exp_rd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (!we || sel[k]) begin
        e.we = we;
        e.a  = b + AW'(k);
        e.d  = we ? wdata[8*k +: 8] : mem[e.a];
        exp_q.push_back(e);
        if (!we) exp_rd[8*k +: 8] = mem[e.a];
      end
    end
    n = exp_q.size();
    len = n * (dly + 1);
    ack_delay = dly;
    log_q.delete();
    @(negedge clk);
    mem_ce = 1'b1; mem_we = we; mem_addr = addr; mem_sel = sel; mem_wdata = wdata;
    busy_n = 0; req_n = 0; done_n = 0; done_at = 0; hold = 1'b0; prev = '0;
    for (int i = 1; i <= len + 3; i++) begin
      @(negedge clk); #1;
      if (mem_busy) busy_n++;
      if (ext_req)  req_n++;
      if (mem_done) begin done_n++; done_at = i; end
      if (hold) begin
        total++;
        if ({ext_we, ext_addr, ext_wdata} !== prev) begin
          bad++;
          $display("FAIL %s hold: got %h want %h at cycle %0d", nm,
                   {ext_we, ext_addr, ext_wdata}, prev, i);
        end
      end
      hold = ext_req && !ext_ack;
      prev = {ext_we, ext_addr, ext_wdata};
      // Junk requests while busy must be ignored.
      mem_ce    = mem_busy ? 1'($urandom) : 1'b0;
      mem_we    = 1'($urandom);
      mem_addr  = $urandom;
      mem_sel   = 4'($urandom);
      mem_wdata = $urandom;
    end
    mem_ce = 1'b0;
    total++;
    if (busy_n !== len) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_n, len); end
    total++;
    if (req_n !== len) begin bad++; $display("FAIL %s req_cycles: got %0d want %0d", nm, req_n, len); end
    total++;
    if (done_n !== (we ? 0 : 1)) begin bad++; $display("FAIL %s done_count: got %0d want %0d", nm, done_n, we ? 0 : 1); end
    if (!we) begin
      total++;
      if (done_at !== len + 1) begin bad++; $display("FAIL %s done_time: got T+%0d want T+%0d", nm, done_at, len + 1); end
    end
    total++;
    if (log_q.size() !== n) begin
      bad++; $display("FAIL %s xfer_count: got %0d want %0d", nm, log_q.size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        total++;
        if (log_q[k] !== exp_q[k]) begin
          bad++; $display("FAIL %s xfer%0d: got %h want %h", nm, k, log_q[k], exp_q[k]);
        end
      end
    end
    if (!we) last_rd = exp_rd;
    total++;
    if (mem_rdata !== last_rd) begin bad++; $display("FAIL %s rdata: got %h want %h", nm, mem_rdata, last_rd); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_ce = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ({mem_busy, mem_done, ext_req, ext_we} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {mem_busy, mem_done, ext_req, ext_we});
    end
    total++;
    if ({mem_rdata, ext_addr, ext_wdata} !== '0) begin
      bad++; $display("FAIL reset_data: got %h/%h/%h want 0", mem_rdata, ext_addr, ext_wdata);
    end
    rst = 1'b1;
    last_rd = 32'h0;
  endtask

  task automatic test_read_basic();
    mem[17'h100] = 8'h11; mem[17'h101] = 8'h22; mem[17'h102] = 8'h33; mem[17'h103] = 8'h44;
    do_op(1'b0, 32'h100, 4'h0, 32'h0, 0, "read_basic");
    total++;
    if (mem_rdata !== 32'h44332211) begin bad++; $display("FAIL read_basic_word: got %h want 44332211", mem_rdata); end
  endtask

  task automatic test_write_sparse();
    do_op(1'b1, 32'h204, 4'b0101, 32'hAABBCCDD, 0, "write_sparse");
    total++;
    if ({mem[17'h204], mem[17'h206]} !== 16'hDDBB) begin
      bad++; $display("FAIL write_sparse_mem: got %h want ddbb", {mem[17'h204], mem[17'h206]});
    end
  endtask

  task automatic test_read_slow();
    do_op(1'b0, 32'h3A0, 4'h0, 32'h0, 3, "read_slow");
  endtask

  task automatic test_write_nop();
    @(negedge clk);
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h500; mem_sel = 4'b0000; mem_wdata = 32'h12345678;
    @(negedge clk); #1;
    mem_ce = 1'b0;
    total++;
    if ({ext_req, mem_busy} !== 2'b00) begin bad++; $display("FAIL write_nop: got req,busy=%b want 00", {ext_req, mem_busy}); end
    do_op(1'b0, 32'h500, 4'h0, 32'h0, 0, "after_nop_read");
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    ack_delay = 1;
    log_q.delete();
    @(negedge clk);
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; mem_sel = 4'h0;
    @(negedge clk); #1;
    mem_ce = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (log_q.size() >= 2) seen = 1'b1;
      else begin @(negedge clk); #1; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL reset_mid_wait: got %0d bytes want 2", log_q.size()); end
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    total++;
    if ({ext_req, mem_busy, mem_done} !== 3'b000) begin
      bad++; $display("FAIL reset_mid_abort: got req,busy,done=%b want 000", {ext_req, mem_busy, mem_done});
    end
    total++;
    if (mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_mid_rdata: got %h want 0", mem_rdata); end
    last_rd = 32'h0;
    for (int k = 0; k < 4; k++) mem[17'h600 + k] = 8'($urandom);
    do_op(1'b0, 32'h600, 4'h0, 32'h0, 0, "reset_mid_fresh");
  endtask

  task automatic test_top_addr();
    do_op(1'b0, 32'h1FFFE, 4'h0, 32'h0, 0, "top_read");
    do_op(1'b1, 32'h1FFFF, 4'b1111, 32'hCAFEF00D, 0, "top_write_wrap");
  endtask

  task automatic test_back_to_back();
    do_op(1'b1, 32'h720, 4'b1111, 32'h01020304, 0, "b2b_write");
    do_op(1'b0, 32'h720, 4'h0, 32'h0, 0, "b2b_read");
    total++;
    if (mem_rdata !== 32'h01020304) begin bad++; $display("FAIL b2b_word: got %h want 01020304", mem_rdata); end
  endtask

  task automatic test_random();
    stray_en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      logic [31:0] a;
      a = (t % 5 == 0) ? (32'h1FFFC + 32'($urandom_range(0, 3))) : $urandom;
      do_op(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 2), "random");
    end
    stray_en = 1'b0;
  endtask

  initial begin
    ext_ack = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    test_reset();
    test_read_basic();
    test_write_sparse();
    test_read_slow();
    test_write_nop();
    test_reset_mid();
    test_top_addr();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
